stb_dcache_wr_responder: RTL and testbench

Data-cache-side responder for the store buffer drain interface. Accepts one buffered store at a time over the `stb2dcache_*` request bus, merges the selected bytes into a word-addressed data array after a configurable write latency, then returns a single-cycle `dcache2stb_ack` so the store buffer can retire the entry. A non-stalling load read port gives the LSU one-cycle reads of the same array.

---
 rtl/stb_dcache_wr_responder.sv | 132 +++++++++++++
 tb/tb_stb_dcache_wr_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_dcache_wr_responder.sv
// Store-buffer drain responder: merges one buffered store into a word array after a
// fixed write latency and acks it; a separate non-stalling port serves LSU loads.
module stb_dcache_wr_responder #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_SEL_WIDTH = 4,
    parameter int unsigned MEM_DEPTH      = 64,
    parameter int unsigned WR_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_w_en,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    output logic                      dcache2stb_ack,
    output logic                      dcache_busy,
    input  logic                      lsu2dcache_rd_req,
    input  logic [ADDR_WIDTH-1:0]     lsu2dcache_rd_addr,
    output logic                      dcache2lsu_rd_valid,
    output logic [DATA_WIDTH-1:0]     dcache2lsu_rd_data
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          hold_idx_q, hold_idx_d;
    logic [DATA_WIDTH-1:0]     hold_wdata_q, hold_wdata_d;
    logic [BYTE_SEL_WIDTH-1:0] hold_sel_q, hold_sel_d;
    logic                      commit_c;
    logic [DATA_WIDTH-1:0]     merged_c;
    logic [IDX_W-1:0]          rd_idx_c;
    logic                      ack_q, busy_q, rd_valid_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
    logic                      unused_addr_bits_c;

    // Only the word-index bits of either address matter; the rest are deliberately dropped.
    assign unused_addr_bits_c = ^{stb2dcache_addr, lsu2dcache_rd_addr};
    assign rd_idx_c           = lsu2dcache_rd_addr[IDX_W+1:2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, holding-register and commit decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_idx_d   = hold_idx_q;
        hold_wdata_d = hold_wdata_q;
        hold_sel_d   = hold_sel_q;
        commit_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb2dcache_req && stb2dcache_w_en) begin
                    hold_idx_d   = stb2dcache_addr[IDX_W+1:2];
                    hold_wdata_d = stb2dcache_wdata;
                    hold_sel_d   = stb2dcache_sel_byte;
                    cnt_d        = CNT_W'(WR_LATENCY - 1);
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte-merge of the held store onto the current array word
    always_comb begin
        merged_c = mem[hold_idx_q];
        for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
            if (hold_sel_q[i]) merged_c[8*i +: 8] = hold_wdata_q[8*i +: 8];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_idx_q   <= '0;
            hold_wdata_q <= '0;
            hold_sel_q   <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            hold_idx_q   <= hold_idx_d;
            hold_wdata_q <= hold_wdata_d;
            hold_sel_q   <= hold_sel_d;
            ack_q        <= (state_d == ACK);
            busy_q       <= (state_d != IDLE);
            rd_valid_q   <= lsu2dcache_rd_req;
            if (lsu2dcache_rd_req) begin
                // Write-first: a same-index read in the commit cycle sees the merged word.
                rd_data_q <= (commit_c && (rd_idx_c == hold_idx_q)) ? merged_c : mem[rd_idx_c];
            end
        end
    end

    // Array write; reset suppresses a commit in the same cycle
    always_ff @(posedge clk) begin
        if (commit_c && !rst) mem[hold_idx_q] <= merged_c;
    end

    assign dcache2stb_ack      = ack_q;
    assign dcache_busy         = busy_q;
    assign dcache2lsu_rd_valid = rd_valid_q;
    assign dcache2lsu_rd_data  = rd_data_q;

endmodule

// File: tb/tb_stb_dcache_wr_responder.sv
// Directed bench for stb_dcache_wr_responder: store handshake timing, byte merge,
// back-to-back throughput, ignored requests, aliasing, write-first reads and reset.
module tb_stb_dcache_wr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, w_en;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        ack, busy;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    stb_dcache_wr_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .stb2dcache_req      (req),
        .stb2dcache_w_en     (w_en),
        .stb2dcache_addr     (addr),
        .stb2dcache_wdata    (wdata),
        .stb2dcache_sel_byte (sel),
        .dcache2stb_ack      (ack),
        .dcache_busy         (busy),
        .lsu2dcache_rd_req   (rd_req),
        .lsu2dcache_rd_addr  (rd_addr),
        .dcache2lsu_rd_valid (rd_valid),
        .dcache2lsu_rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Advance into the next cycle; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store in the current cycle (cycle 0); report ack cycle and busy cycle count.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output int ack_cyc, output int busy_cyc);
        ack_cyc  = -1;
        busy_cyc = 0;
        req = 1'b1; w_en = 1'b1; addr = a; wdata = d; sel = s;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (busy) busy_cyc++;
            if (ack) begin
                ack_cyc = c;
                break;
            end
        end
        req = 1'b0; w_en = 1'b0;
    endtask

    // One-cycle load; returns what is visible in the following cycle.
    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
        rd_req = 1'b1; rd_addr = a;
        tick();
        v = rd_valid;
        d = rd_data;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; w_en = 1'b0; addr = '0; wdata = '0; sel = '0;
        rd_req = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({ack, busy, rd_valid} !== 3'b000 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b busy=%b rd_valid=%b rd_data=%h, want all 0",
                     ack, busy, rd_valid, rd_data);
        end
    endtask

    task automatic test_basic_store();
        int ac, bc;
        logic v;
        logic [31:0] d;
        drive_store(32'h10, 32'hDEADBEEF, 4'hF, ac, bc);
        total++;
        if (ac !== 3) begin bad++; $display("FAIL basic_ack_cycle: got %0d want 3", ac); end
        total++;
        if (bc !== 3) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 3", bc); end
        tick();
        total++;
        if ({ack, busy} !== 2'b00) begin
            bad++; $display("FAIL basic_after_ack: ack=%b busy=%b want 0 0", ack, busy);
        end
        do_read(32'h10, v, d);
        total++;
        if (v !== 1'b1 || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL basic_read: valid=%b data=%h want 1 deadbeef", v, d);
        end
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_hold: valid=%b data=%h want 0 deadbeef", rd_valid, rd_data);
        end
    endtask

    task automatic test_byte_merge();
        int ac, bc;
        logic v;
        logic [31:0] d;
        drive_store(32'h10, 32'h11223344, 4'hF, ac, bc);
        tick();
        drive_store(32'h10, 32'hAABBCCDD, 4'h5, ac, bc);
        tick();
        do_read(32'h10, v, d);
        total++;
        if (d !== 32'h11BB33DD) begin bad++; $display("FAIL merge_sel5: got %h want 11bb33dd", d); end
        drive_store(32'h10, 32'hFFFFFFFF, 4'h0, ac, bc);
        total++;
        if (ac !== 3) begin bad++; $display("FAIL sel0_ack: got cycle %0d want 3", ac); end
        tick();
        do_read(32'h10, v, d);
        total++;
        if (d !== 32'h11BB33DD) begin bad++; $display("FAIL sel0_unchanged: got %h want 11bb33dd", d); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int acks[4] = '{-1, -1, -1, -1};
        logic v;
        logic [31:0] d;
        req = 1'b1; w_en = 1'b1; addr = 32'h40; wdata = 32'hA0000000; sel = 4'hF;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            tick();
            if (ack) begin
                acks[n] = c;
                n++;
                addr  = 32'h40 + 32'(4 * n);
                wdata = 32'hA0000000 + 32'(n);
                if (n == 4) begin req = 1'b0; w_en = 1'b0; end
            end
        end
        req = 1'b0; w_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acks[i] !== 3 + 4 * i) begin
                bad++; $display("FAIL b2b_ack%0d: got cycle %0d want %0d", i, acks[i], 3 + 4 * i);
            end
        end
        tick();
        do_read(32'h4C, v, d);
        total++;
        if (d !== 32'hA0000003) begin bad++; $display("FAIL b2b_last_data: got %h want a0000003", d); end
    endtask

    task automatic test_ignored_req();
        int acks = 0, busys = 0;
        req = 1'b1; w_en = 1'b0; addr = 32'h10; wdata = 32'h0; sel = 4'hF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (ack) acks++;
            if (busy) busys++;
        end
        req = 1'b0;
        total++;
        if (acks !== 0 || busys !== 0) begin
            bad++; $display("FAIL ignored_req: acks=%0d busy_cycles=%0d want 0 0", acks, busys);
        end
    endtask

    task automatic test_aliasing();
        int ac, bc;
        logic v;
        logic [31:0] d;
        drive_store(32'h103, 32'h0BADF00D, 4'hF, ac, bc);
        tick();
        drive_store(32'h100, 32'hCAFEBABE, 4'hF, ac, bc);
        tick();
        do_read(32'h0, v, d);
        total++;
        if (d !== 32'hCAFEBABE) begin bad++; $display("FAIL alias_overwrite: got %h want cafebabe", d); end
    endtask

    task automatic test_write_first();
        int ac, bc;
        logic [31:0] d2;
        logic        a3;
        drive_store(32'h20, 32'h01020304, 4'hF, ac, bc);
        tick();
        req = 1'b1; w_en = 1'b1; addr = 32'h20; wdata = 32'hA0B0C0D0; sel = 4'h3;
        tick();                              // cycle 1
        rd_req = 1'b1; rd_addr = 32'h20;
        tick();                              // cycle 2: commit cycle
        d2 = rd_data;
        tick();                              // cycle 3
        a3 = ack;
        rd_req = 1'b0; req = 1'b0; w_en = 1'b0;
        total++;
        if (d2 !== 32'h01020304) begin bad++; $display("FAIL pre_commit_read: got %h want 01020304", d2); end
        total++;
        if (rd_data !== 32'h0102C0D0 || rd_valid !== 1'b1) begin
            bad++; $display("FAIL write_first: valid=%b data=%h want 1 0102c0d0", rd_valid, rd_data);
        end
        total++;
        if (a3 !== 1'b1) begin bad++; $display("FAIL write_first_ack: ack=%b want 1", a3); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int ac, bc, late_acks = 0;
        logic v;
        logic [31:0] d;
        drive_store(32'h30, 32'h55667788, 4'hF, ac, bc);
        tick();
        req = 1'b1; w_en = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; sel = 4'hF;
        tick(); tick();                      // cycle 2
        rst = 1'b1; rd_req = 1'b1; rd_addr = 32'h30;
        tick();                              // cycle 3
        rst = 1'b0; rd_req = 1'b0; req = 1'b0; w_en = 1'b0;
        total++;
        if ({ack, busy, rd_valid} !== 3'b000 || rd_data !== 32'h0) begin
            bad++; $display("FAIL midop_reset_outputs: ack=%b busy=%b valid=%b data=%h want 0",
                            ack, busy, rd_valid, rd_data);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack) late_acks++;
        end
        total++;
        if (late_acks !== 0) begin bad++; $display("FAIL midop_no_ack: got %0d acks want 0", late_acks); end
        do_read(32'h30, v, d);
        total++;
        if (d !== 32'h55667788) begin bad++; $display("FAIL midop_mem_kept: got %h want 55667788", d); end
        drive_store(32'h30, 32'h12345678, 4'hF, ac, bc);
        total++;
        if (ac !== 3) begin bad++; $display("FAIL post_reset_ack: got cycle %0d want 3", ac); end
        tick();
        do_read(32'h30, v, d);
        total++;
        if (d !== 32'h12345678) begin bad++; $display("FAIL post_reset_data: got %h want 12345678", d); end
    endtask

    initial begin
        test_reset();
        test_basic_store();
        test_byte_merge();
        test_back_to_back();
        test_ignored_req();
        test_aliasing();
        test_write_first();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
